// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the time-shared multiplier controller.
package binary_mul_pkg;

    localparam int DEFAULT_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        CAP,
        RESP
    } state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/binary_mul_rr_pick.sv
// Round-robin requester picker: first valid requester at or after ptr, wrapping.
module binary_mul_rr_pick
    import binary_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  g,
    output logic             any_valid
);

    logic [ID_W-1:0] idx;

    // Walk ptr, ptr+1, ... modulo N_REQ and latch onto the first valid requester.
    always_comb begin
        grant     = '0;
        g         = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                g          = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/binary_mul_share_ctrl.sv
// Controller that time-shares one registered multiplier among N_REQ requesters,
// one operation in flight, round-robin arbitration, valid/ready on both sides.
module binary_mul_share_ctrl
    import binary_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*WIDTH-1:0]       req_a,
    input  logic [N_REQ*WIDTH-1:0]       req_b,
    output logic                         mul_en,
    output logic [WIDTH-1:0]             mul_a,
    output logic [WIDTH-1:0]             mul_b,
    input  logic [prod_width(WIDTH)-1:0] mul_p,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [prod_width(WIDTH)-1:0] rsp_p,
    output logic                         busy
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t           state;
    state_t           next_state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  g;
    logic             any_valid;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             accept;

    binary_mul_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .g         (g),
        .any_valid (any_valid)
    );

    assign accept = (state == IDLE) && any_valid;
    assign mul_a  = op_a;
    assign mul_b  = op_b;

    // Select the granted requester's operands with the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                sel_a = req_a[k*WIDTH +: WIDTH];
                sel_b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // State register; reset always lands in IDLE, discarding any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; only IDLE may accept, so every op passes through IDLE.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        mul_en     = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_valid) begin
                    req_ready  = rst_n ? grant : '0;
                    next_state = MUL;
                end
            end
            MUL: begin
                mul_en = 1'b1;
                if (cnt == '0) begin
                    next_state = CAP;
                end
            end
            CAP: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, latency countdown in MUL, product capture in CAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            rsp_id <= '0;
            rsp_p  <= '0;
        end else begin
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                rsp_id <= g;
                ptr    <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
                cnt    <= CNT_W'(MUL_LAT - 1);
            end else if (state == MUL && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == CAP) begin
                rsp_p <= mul_p;
            end
        end
    end

endmodule

// File: doc/binary_mul_share_ctrl.md
Name: binary_mul_share_ctrl

Overview:
- Time-shares one registered unsigned multiplier (11x11 -> 22, synchronous enable, output held while en=0) among N_REQ requesters.
- Round-robin arbitration; valid/ready handshake on both request and response sides.
- One operation in flight at a time. Sits between requester blocks and the single multiplier instance.

Parameters:
- N_REQ, 4: number of requesters (>=1)
- WIDTH, 11: operand width; product width is 2*WIDTH
- MUL_LAT, 1: multiplier latency in enabled cycles (>=1)
- ID_W, max(1,$clog2(N_REQ)): requester-index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A; requester k at [k*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B; same slicing
- mul_en  out  1  multiplier enable
- mul_a  out  WIDTH  multiplier operand A
- mul_b  out  WIDTH  multiplier operand B
- mul_p  in  2*WIDTH  multiplier product
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  ID_W  requester index of the result
- rsp_p  out  2*WIDTH  product
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the rising edge.
- Reset values: state=IDLE, ptr=0, op_a=op_b=0, rsp_id=0, rsp_p=0, mul_en=0, rsp_valid=0, req_ready=0, busy=0.
- States:
  - IDLE -> MUL on accept.
  - MUL -> CAP after MUL_LAT cycles (down-counter loaded with MUL_LAT-1).
  - CAP -> RESP always.
  - RESP -> IDLE on rsp_valid && rsp_ready.
- Arbitration, combinational in IDLE only:
  - Grant g = first k with req_valid[k], searching ptr, ptr+1, ... modulo N_REQ.
  - req_ready[g]=1 only in IDLE with any valid; all zeros in every other state.
- Accept edge (IDLE, any req_valid): op_a<=req_a[g], op_b<=req_b[g], rsp_id<=g, ptr<=(g+1) mod N_REQ.
- Multiplier drive: mul_a=op_a and mul_b=op_b at all times; mul_en=1 exactly in MUL cycles.
- CAP: rsp_p<=mul_p, taken one cycle after the last enabled edge.
- RESP: rsp_valid=1; rsp_p and rsp_id stable until handshake. rsp_ready low stalls indefinitely with no new accepts.
- Latency: accept edge to first rsp_valid cycle = MUL_LAT+2 cycles. Minimum issue interval = MUL_LAT+3 cycles. No accept in the cycle a response handshakes; IDLE is always visited.
- Boundary conditions:
  - req_valid dropping before grant: nothing committed; no requester is ever blocked by ptr.
  - All requesters valid continuously: served ptr, ptr+1, ... in strict rotation.
  - Single persistent requester: served every MUL_LAT+3 cycles.
  - N_REQ=1: grant is always 0; rsp_id=0.
  - Operand changes after accept have no effect on the in-flight op.
  - Max operands (2^WIDTH-1)^2 fit in 2*WIDTH bits; no truncation.
  - rst_n low in any state, including mid-MUL or stalled RESP: next edge returns to reset values; in-flight result discarded; ptr=0.

Decomposition:
- Shared package binary_mul_pkg: state enum (IDLE, MUL, CAP, RESP), default WIDTH=11, product-width function.
- One sub-module binary_mul_rr_pick: purely combinational, inputs req_valid and ptr, outputs one-hot grant, index g and any_valid. FSM, counter and registers stay in the top.

Test Plan:
- Reset mid-MUL: after reset, req_valid[2]=1, A=2047, B=2047 -> accept; 3 cycles later rsp_valid=1, rsp_id=2, rsp_p=4190209. Assert rst_n=0 in MUL -> next cycle all outputs at reset values.
- All four valid from reset with distinct operands (k*3, k+5) -> rsp_id sequence 0,1,2,3,0; each product correct; req_ready one-hot.
- rsp_ready held low 10 cycles in RESP -> rsp_valid, rsp_p, rsp_id stable; req_ready all 0; release -> IDLE next cycle.
- Fairness: ptr=2 after grant to 1, requesters 0 and 3 valid -> 3 granted before 0.
- Operand change: change req_a of the granted requester on the cycle after accept -> result uses the original operand.
- Exhaustive sweep: A,B over 0..2047 through requester 0 with MUL_LAT=1, compared against the reference model -> zero mismatches; throughput exactly one result per 4 cycles.
